output_drain: RTL

- Downstream consumer of the MAC-array result stream: `out`, `output_valid`, `output_x`, `output_y` and `output_ch`.
- Requantizes each ACCUMULATION_WIDTH result to IO_DATA_WIDTH with rounding and saturation.
- Buffers results in a small FIFO and presents them to the host on a valid/ready stream with frame-end marking.
- The producer has no backpressure, so the block exports an almost-full hint to the controller and a sticky overflow flag.

---
 rtl/output_drain.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/output_drain.sv
// output_drain
//   Receives the MAC-array result stream, requantizes each accumulator value
//   to the output width with round-half-up and saturation, buffers the results
//   in a first-word fall-through FIFO, and presents them to the host on a
//   valid/ready stream. The producer cannot be stalled, so an almost-full hint
//   and a sticky overflow flag are exported.
//
// Ports
//   clk, rst_in            clock, synchronous active-high reset
//   in_valid/in_data/in_x/in_y/in_ch   incoming result and its coordinates
//   almost_full            registered: occupancy >= AF_THRESHOLD
//   overflow, clear_overflow           sticky drop flag and its clear
//   out_valid/out_ready    host handshake for the head entry
//   out_data/out_x/out_y/out_ch/out_last   head entry (zero when empty)
//   level                  current occupancy
module output_drain #(
  parameter int ACCUMULATION_WIDTH = 32,
  parameter int IO_DATA_WIDTH      = 16,
  parameter int OUTPUT_SCALE       = 0,
  parameter int FEATURE_MAP_WIDTH  = 1024,
  parameter int FEATURE_MAP_HEIGHT = 1024,
  parameter int OUTPUT_NB_CHANNELS = 64,
  parameter int FIFO_DEPTH         = 8,
  parameter int AF_THRESHOLD       = FIFO_DEPTH - 2
) (
  input  logic                                    clk,
  input  logic                                    rst_in,
  input  logic                                    in_valid,
  input  logic signed [ACCUMULATION_WIDTH-1:0]    in_data,
  input  logic [$clog2(FEATURE_MAP_WIDTH)-1:0]    in_x,
  input  logic [$clog2(FEATURE_MAP_HEIGHT)-1:0]   in_y,
  input  logic [$clog2(OUTPUT_NB_CHANNELS)-1:0]   in_ch,
  output logic                                    almost_full,
  output logic                                    overflow,
  input  logic                                    clear_overflow,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic signed [IO_DATA_WIDTH-1:0]         out_data,
  output logic [$clog2(FEATURE_MAP_WIDTH)-1:0]    out_x,
  output logic [$clog2(FEATURE_MAP_HEIGHT)-1:0]   out_y,
  output logic [$clog2(OUTPUT_NB_CHANNELS)-1:0]   out_ch,
  output logic                                    out_last,
  output logic [$clog2(FIFO_DEPTH):0]             level
);

  localparam int ACC = ACCUMULATION_WIDTH;
  localparam int IOW = IO_DATA_WIDTH;
  localparam int XW  = $clog2(FEATURE_MAP_WIDTH);
  localparam int YW  = $clog2(FEATURE_MAP_HEIGHT);
  localparam int CW  = $clog2(OUTPUT_NB_CHANNELS);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int LW  = AW + 1;

  localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] AF_L    = LW'(AF_THRESHOLD);

  localparam logic [XW-1:0] X_LAST  = XW'(FEATURE_MAP_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST  = YW'(FEATURE_MAP_HEIGHT - 1);
  localparam logic [CW-1:0] CH_LAST = CW'(OUTPUT_NB_CHANNELS - 1);

  // Half an output LSB; zero when no shift is applied so the add is a no-op.
  localparam int RND_SH = (OUTPUT_SCALE == 0) ? 0 : OUTPUT_SCALE - 1;
  localparam logic signed [ACC:0] RND =
    (OUTPUT_SCALE == 0) ? '0 : ({{ACC{1'b0}}, 1'b1} << RND_SH);

  localparam logic signed [ACC:0]   SAT_MAX = {{(ACC-IOW+2){1'b0}}, {(IOW-1){1'b1}}};
  localparam logic signed [ACC:0]   SAT_MIN = {{(ACC-IOW+2){1'b1}}, {(IOW-1){1'b0}}};
  localparam logic signed [IOW-1:0] OUT_MAX = {1'b0, {(IOW-1){1'b1}}};
  localparam logic signed [IOW-1:0] OUT_MIN = {1'b1, {(IOW-1){1'b0}}};

  // One guard bit keeps the rounding add from wrapping at the positive limit.
  function automatic logic signed [ACC:0] round_shift(input logic signed [ACC-1:0] d);
    logic signed [ACC:0] ext;
    ext = {d[ACC-1], d};
    return (ext + RND) >>> OUTPUT_SCALE;
  endfunction

  function automatic logic signed [IOW-1:0] saturate(input logic signed [ACC:0] v);
    if (v > SAT_MAX)      return OUT_MAX;
    else if (v < SAT_MIN) return OUT_MIN;
    else                  return v[IOW-1:0];
  endfunction

  logic signed [IOW-1:0] mem_data [FIFO_DEPTH];
  logic [XW-1:0]         mem_x    [FIFO_DEPTH];
  logic [YW-1:0]         mem_y    [FIFO_DEPTH];
  logic [CW-1:0]         mem_ch   [FIFO_DEPTH];
  logic                  mem_last [FIFO_DEPTH];

  logic [AW-1:0]         rd_ptr, wr_ptr;
  logic [LW-1:0]         level_nxt;
  logic                  push, pop;
  logic signed [IOW-1:0] wdata_p0;
  logic                  wlast_p0;

  // Stage p0: requantize and tag the incoming word before it is stored.
  assign wdata_p0 = saturate(round_shift(in_data));
  assign wlast_p0 = (in_x == X_LAST) && (in_y == Y_LAST) && (in_ch == CH_LAST);

  assign out_valid = (level != '0);
  assign pop       = out_valid && out_ready;
  // A pop frees a slot in the same edge, so a full FIFO still accepts then.
  assign push      = in_valid && ((level < DEPTH_L) || pop);

  always_comb begin
    level_nxt = level;
    case ({push, pop})
      2'b10:   level_nxt = level + LW'(1);
      2'b01:   level_nxt = level - LW'(1);
      default: level_nxt = level;
    endcase
  end

  // Storage holds data only; validity is tracked by the control registers.
  always_ff @(posedge clk) begin
    if (push && !rst_in) begin
      mem_data[wr_ptr] <= wdata_p0;
      mem_x[wr_ptr]    <= in_x;
      mem_y[wr_ptr]    <= in_y;
      mem_ch[wr_ptr]   <= in_ch;
      mem_last[wr_ptr] <= wlast_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      level       <= '0;
      almost_full <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      level       <= level_nxt;
      almost_full <= (level_nxt >= AF_L);
      // A drop in the same cycle as a clear wins.
      if (in_valid && !push)  overflow <= 1'b1;
      else if (clear_overflow) overflow <= 1'b0;
    end
  end

  // Stage p1: head entry, forced to zero while the FIFO is empty.
  assign out_data = out_valid ? mem_data[rd_ptr] : '0;
  assign out_x    = out_valid ? mem_x[rd_ptr]    : '0;
  assign out_y    = out_valid ? mem_y[rd_ptr]    : '0;
  assign out_ch   = out_valid ? mem_ch[rd_ptr]   : '0;
  assign out_last = out_valid ? mem_last[rd_ptr] : 1'b0;

endmodule
